// File: rtl/run_ctrl_pkg.sv
// Shared types and default configuration for the run_ctrl program sequencer.
// Record fields are sized here, so an NPROG override must still fit in PW.
package run_ctrl_pkg;

    localparam int DEF_NPROG   = 3;
    localparam int DEF_RST_CYC = 2;
    localparam int DEF_TMO     = 4000;
    localparam int CW          = 16;
    localparam int PW          = (DEF_NPROG > 1) ? $clog2(DEF_NPROG) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        REPORT,
        FINISH
    } state_e;

    typedef struct packed {
        logic [PW-1:0] prog;
        logic [CW-1:0] count;
        logic          tmo;
    } rec_t;

    function automatic logic is_busy(state_e s);
        return (s == HOLD) || (s == RUN) || (s == REPORT);
    endfunction

endpackage

// File: rtl/run_ctrl_if.sv
// Harness-facing bundle of run_ctrl: start request, core handshake and record output.
interface run_ctrl_if;
    import run_ctrl_pkg::*;

    logic          start;
    logic          core_done;
    logic          core_reset;
    logic [PW-1:0] prog_idx;
    logic          busy;
    logic          rec_valid;
    logic [PW-1:0] rec_prog;
    logic [CW-1:0] rec_count;
    logic          rec_tmo;
    logic          all_done;

    modport master (
        output start,
        output core_done,
        input  core_reset,
        input  prog_idx,
        input  busy,
        input  rec_valid,
        input  rec_prog,
        input  rec_count,
        input  rec_tmo,
        input  all_done
    );

    modport slave (
        input  start,
        input  core_done,
        output core_reset,
        output prog_idx,
        output busy,
        output rec_valid,
        output rec_prog,
        output rec_count,
        output rec_tmo,
        output all_done
    );

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         at_max_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign at_max_o = &count_q;
    assign count_o  = count_q;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !at_max_o) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Sequencer that resets the core, times each program run and emits one record per program.
// Optional run-cycle timeout is enabled by defining RUN_CTRL_TIMEOUT_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int NPROG   = DEF_NPROG,
    parameter int RST_CYC = DEF_RST_CYC,
    parameter int TMO     = DEF_TMO
) (
    input logic        clk,
    input logic        reset,
    run_ctrl_if.slave  bus
);

    localparam int            HW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_CYC - 1);
    localparam logic [PW-1:0] LAST_PROG = PW'(NPROG - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO - 1);
    localparam logic [CW-1:0] TMO_COUNT = CW'(TMO);
`ifdef RUN_CTRL_TIMEOUT_EN
    localparam bit            TMO_EN    = 1'b1;
`else
    localparam bit            TMO_EN    = 1'b0;
`endif

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [PW-1:0] prog_q, prog_d;
    rec_t          rec_q, rec_d;
    logic          rec_valid_q, rec_valid_d;
    logic          core_reset_q, core_reset_d;
    logic          busy_q, busy_d;
    logic          all_done_q, all_done_d;

    logic          cnt_clr;
    logic          cnt_en;
    logic          cnt_at_max;
    logic [CW-1:0] cnt;
    logic          run_done;
    logic          run_tmo;

    sat_counter #(.W(CW)) u_cycles (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (cnt_clr),
        .en_i     (cnt_en),
        .count_o  (cnt),
        .at_max_o (cnt_at_max)
    );

    // A done in the timeout cycle wins, so the timeout term requires core_done low.
    assign run_done = (state_q == RUN) && bus.core_done;
    assign run_tmo  = TMO_EN && (state_q == RUN) && !bus.core_done && (cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            prog_q       <= '0;
            rec_q        <= '0;
            rec_valid_q  <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            all_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            prog_q       <= prog_d;
            rec_q        <= rec_d;
            rec_valid_q  <= rec_valid_d;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            all_done_q   <= all_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, FINISH: if (bus.start) state_d = HOLD;
            HOLD:         if (hold_q == '0) state_d = RUN;
            RUN:          if (run_done || run_tmo) state_d = REPORT;
            REPORT:       state_d = (prog_q == LAST_PROG) ? FINISH : HOLD;
            default:      state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        hold_d  = hold_q;
        prog_d  = prog_q;
        rec_d   = rec_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state_q)
            IDLE, FINISH: begin
                if (bus.start) begin
                    hold_d = HOLD_LOAD;
                    prog_d = '0;
                end
            end
            HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HW'(1);
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            RUN: begin
                cnt_en = !bus.core_done && !cnt_at_max;
                if (run_done) begin
                    rec_d = '{prog: prog_q, count: cnt, tmo: 1'b0};
                end else if (run_tmo) begin
                    rec_d = '{prog: prog_q, count: TMO_COUNT, tmo: 1'b1};
                end
            end
            REPORT: begin
                if (prog_q != LAST_PROG) begin
                    prog_d = prog_q + PW'(1);
                    hold_d = HOLD_LOAD;
                end
            end
            default: ;
        endcase
        core_reset_d = (state_d != RUN);
        busy_d       = is_busy(state_d);
        all_done_d   = (state_d == FINISH);
        rec_valid_d  = (state_d == REPORT);
    end

    assign bus.core_reset = core_reset_q;
    assign bus.prog_idx   = prog_q;
    assign bus.busy       = busy_q;
    assign bus.rec_valid  = rec_valid_q;
    assign bus.rec_prog   = rec_q.prog;
    assign bus.rec_count  = rec_q.count;
    assign bus.rec_tmo    = rec_q.tmo;
    assign bus.all_done   = all_done_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomised directed bench for run_ctrl: expected per-cycle behaviour is derived from
// each program's planned run length; covers RUN_CTRL_TIMEOUT_EN when that macro is set.
module tb_run_ctrl;
    import run_ctrl_pkg::*;

    localparam int NPROG_TB = 3;
    localparam int RST_TB   = 2;
    localparam int TMO_TB   = 20;

    localparam int K_IDLE   = 0;
    localparam int K_HOLD   = 1;
    localparam int K_RUN    = 2;
    localparam int K_REPORT = 3;
    localparam int K_FINISH = 4;

    logic clk = 1'b0;
    logic reset;
    int   compared   = 0;
    int   mismatched = 0;
    int   lens[$];
    logic staleDone;
    int   lastProg  = 0;
    int   lastCount = 0;
    int   lastTmo   = 0;

    run_ctrl_if bus ();

    run_ctrl #(
        .NPROG   (NPROG_TB),
        .RST_CYC (RST_TB),
        .TMO     (TMO_TB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic noiseDone();
        return staleDone ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    function automatic logic noiseStart();
        return 1'($urandom_range(0, 4) == 0);
    endfunction

    task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s at %0t: observed=%0d expected=%0d", tag, $time, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic rstIn, input logic startIn, input logic doneIn);
        reset         = rstIn;
        bus.start     = startIn;
        bus.core_done = doneIn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input int kind, input int prog, input int count, input int tmo);
        expectEq("core_reset", 32'(bus.core_reset), 32'(kind != K_RUN));
        expectEq("busy", 32'(bus.busy), 32'(kind == K_HOLD || kind == K_RUN || kind == K_REPORT));
        expectEq("all_done", 32'(bus.all_done), 32'(kind == K_FINISH));
        expectEq("rec_valid", 32'(bus.rec_valid), 32'(kind == K_REPORT));
        expectEq("prog_idx", 32'(bus.prog_idx), prog);
        if (kind == K_REPORT) begin
            expectEq("rec_prog", 32'(bus.rec_prog), prog);
            expectEq("rec_count", 32'(bus.rec_count), count);
            expectEq("rec_tmo", 32'(bus.rec_tmo), tmo);
            lastProg  = prog;
            lastCount = count;
            lastTmo   = tmo;
        end else if (kind == K_IDLE) begin
            expectEq("idle_rec_prog", 32'(bus.rec_prog), 0);
            expectEq("idle_rec_count", 32'(bus.rec_count), 0);
            expectEq("idle_rec_tmo", 32'(bus.rec_tmo), 0);
        end else if (kind == K_FINISH) begin
            expectEq("held_rec_prog", 32'(bus.rec_prog), lastProg);
            expectEq("held_rec_count", 32'(bus.rec_count), lastCount);
            expectEq("held_rec_tmo", 32'(bus.rec_tmo), lastTmo);
        end
    endtask

    task automatic step(input logic rstIn, input logic startIn, input logic doneIn,
                        input int kind, input int prog, input int count, input int tmo);
        applyStimulus(rstIn, startIn, doneIn);
        checkOutput(kind, prog, count, tmo);
    endtask

    // One start-to-FINISH pass: RST_TB hold cycles, len+1 run cycles, one report per program.
    // Inputs of each step are seen by the design in the phase observed at the previous step.
    task automatic runSequence(input int abortProg, input int abortRun);
        bit tmoHit;
        int runObs;
        int expCount;
        for (int p = 0; p < NPROG_TB; p++) begin
            for (int h = 0; h < RST_TB; h++) begin
                step(1'b0, (p == 0 && h == 0) ? 1'b1 : noiseStart(), noiseDone(), K_HOLD, p, 0, 0);
            end
            tmoHit = 1'b0;
`ifdef RUN_CTRL_TIMEOUT_EN
            tmoHit = (lens[p] < 0) || (lens[p] > TMO_TB - 1);
`endif
            runObs   = tmoHit ? TMO_TB : lens[p] + 1;
            expCount = tmoHit ? TMO_TB : lens[p];
            for (int r = 0; r < runObs; r++) begin
                step(1'b0, noiseStart(), (r == 0) ? noiseDone() : 1'b0, K_RUN, p, 0, 0);
                if (p == abortProg && r == abortRun) begin
                    step(1'b1, 1'b1, 1'b1, K_IDLE, 0, 0, 0);
                    repeat (4) step(1'b0, 1'b0, noiseDone(), K_IDLE, 0, 0, 0);
                    return;
                end
            end
            step(1'b0, noiseStart(), tmoHit ? 1'b0 : 1'b1, K_REPORT, p, expCount, int'(tmoHit));
        end
        step(1'b0, noiseStart(), noiseDone(), K_FINISH, NPROG_TB - 1, 0, 0);
        repeat (3) step(1'b0, 1'b0, noiseDone(), K_FINISH, NPROG_TB - 1, 0, 0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.core_done = 1'b0;
        staleDone     = 1'b0;

        $display("[TB] reset and idle");
        repeat (2) step(1'b1, 1'b0, 1'b0, K_IDLE, 0, 0, 0);
        repeat (10) step(1'b0, 1'b0, noiseDone(), K_IDLE, 0, 0, 0);

        $display("[TB] basic sequence 5/9/1");
        lens = '{5, 9, 1};
        runSequence(-1, -1);

        $display("[TB] restart from FINISH with done stuck high outside RUN");
        staleDone = 1'b1;
        lens = '{3, 0, 7};
        runSequence(-1, -1);
        staleDone = 1'b0;

        $display("[TB] random run lengths");
        repeat (4) begin
            lens = {};
            for (int i = 0; i < NPROG_TB; i++) lens.push_back(int'($urandom_range(0, 12)));
            runSequence(-1, -1);
        end

        $display("[TB] reset during RUN of program 1");
        lens = '{4, 6, 2};
        runSequence(1, 3);

`ifdef RUN_CTRL_TIMEOUT_EN
        $display("[TB] timeout on program 0, done on the last counted cycle of program 2");
        lens = '{-1, 4, TMO_TB - 1};
        runSequence(-1, -1);
`else
        $display("[TB] no timeout: program 0 stays in RUN");
        lens = '{1000, 1, 1};
        runSequence(0, 100);
`endif

        $display("[TB] final random sequence");
        lens = {};
        for (int i = 0; i < NPROG_TB; i++) lens.push_back(int'($urandom_range(0, 12)));
        runSequence(-1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
